wandr_seq: RTL and testbench
============================

# wandr_seq

Parametrised SRAM write/readback sequencer for the BNN test path. It takes ownership of the BNN core's weight/activation SRAM through SRAMMUX/PAUSE, then:
- writes a generated pattern over an address range, and/or
- reads the range back, comparing against the expected pattern or streaming it out.

It generalises the fixed single-bit serial loader to configurable address width, data width, bank count, read latency and four run modes. It also adds error counting and a hold input.

## Interface
- AW, 13, SRAM address width
- DW, 1, SRAM data width
- NBANK, 2, number of SRAM banks; SRAMSEL width is $clog2(NBANK), minimum 1
- READ_LAT, 1, cycles from a read access (SRAMCEN=0, SRAMWEN=1) to valid SRAMDOUT; range 1..4
- sysclk  in  1  system clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled in IDLE only
- mode  in  2  00 write-only, 01 verify-only, 10 write-then-verify, 11 read-dump; latched on start
- bank  in  SW  bank select; latched on start
- base_addr  in  AW  first address; latched on start
- last_addr  in  AW  final address, inclusive; latched on start
- pat  in  DW  pattern word; latched on start
- hold  in  1  stall request; inserts idle access slots
- SRAMDOUT  in  DW  SRAM read data
- SRAMA  out  AW  SRAM address
- SRAMD  out  DW  SRAM write data
- SRAMCEN  out  1  chip enable, active-low
- SRAMWEN  out  1  write enable, active-low
- SRAMSEL  out  SW  bank select
- SRAMMUX  out  1  1 = sequencer owns SRAM, 0 = BNN core owns it
- PAUSE  out  1  holds BNN core while sequencer owns SRAM
- rd_data  out  DW  read data (all read modes)
- rd_valid  out  1  rd_data valid, one-cycle strobe per address
- busy  out  1  high from SETUP through DONE
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky mismatch flag, cleared on start
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- err_addr  out  AW  address of first mismatch

## Operation
- States: IDLE, SETUP, WRITE, RGAP, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches mode/bank/base/last/pat, clears err/err_cnt/err_addr, then goes to SETUP.
  - start outside IDLE is ignored.
- SETUP: one cycle.
  - SRAMMUX=1, PAUSE=1, SRAMSEL=bank, SRAMCEN=1.
  - Goes to WRITE for modes 00/10, READ for modes 01/11.
- Address sequence:
  - Runs base_addr, base+1, … last_addr, modulo 2^AW.
  - If last_addr < base_addr, it wraps through all-ones to 0.
  - N = ((last_addr − base_addr) mod 2^AW) + 1.
- Expected data: exp(a) = pat ^ {DW{a[0]}} (checkerboard).
- WRITE: one access per non-held cycle, with SRAMCEN=0, SRAMWEN=0, SRAMA=a, SRAMD=exp(a).
  - After address N: mode 00 goes to DONE, mode 10 goes to RGAP.
- RGAP: one cycle with SRAMCEN=1 and SRAMWEN=1 for the write→read turnaround, then READ.
- READ: one access per non-held cycle, with SRAMCEN=0, SRAMWEN=1, SRAMA=a.
  - Each access pushes (valid, a, exp(a)) into a READ_LAT-deep shift pipeline.
  - After address N, goes to DRAIN.
- Pipeline output:
  - When a valid entry emerges: rd_data=SRAMDOUT, rd_valid=1.
  - In modes 01/10, compare with the stored exp. On mismatch: err=1, err_cnt+1 (saturating), and err_addr=a if this is the first mismatch.
  - Mode 11 never compares.
- DRAIN: READ_LAT cycles, SRAMCEN=1, pipeline empties, then DONE.
- DONE: one cycle with done=1 and busy=1; SRAMMUX and PAUSE stay 1. Then IDLE, where SRAMMUX=0 and PAUSE=0.
- hold:
  - In WRITE/READ, a cycle with hold=1 drives SRAMCEN=1 and SRAMWEN=1, and the address does not advance.
  - The pipeline still shifts and pushes a bubble, so in-flight reads complete and compare normally.
  - hold is ignored in all other states.
- RST, including mid-run: takes effect at the next edge. The FSM returns to IDLE and every output takes its reset value. The SRAM is released immediately; no drain occurs.

## Timing
- Reset values:
  - SRAMA=0, SRAMD=0, SRAMCEN=1, SRAMWEN=1, SRAMSEL=0, SRAMMUX=0, PAUSE=0.
  - rd_data=0, rd_valid=0, busy=0, done=0, err=0, err_cnt=0, err_addr=0.
- All outputs are registered.
- Cycle 0 is the edge that samples start. SETUP occupies cycle 1 and the first access occurs in cycle 2.
- Run lengths with no hold, from start sample to done (inclusive):
  - Mode 00: N+2 cycles.
  - Modes 01/11: N+READ_LAT+2.
  - Mode 10: 2N+READ_LAT+3.
- Each held cycle adds exactly one cycle.
- rd_valid for a read issued in cycle k is asserted in cycle k+READ_LAT.
- busy falls, and SRAMMUX/PAUSE fall, in the cycle after done.

## Test plan
- DW=8, mode 10, base 0, last 7, pat 8'hA5, ideal SRAM model, READ_LAT=1 -> writes A5,5A,A5,…; 8 rd_valid strobes; done 20 cycles after start; err=0, err_cnt=0.
- Same, but the model flips bit 0 at address 3 -> err=1, err_cnt=1, err_addr=3; done at the same cycle.
- AW=4, mode 00, base 14, last 1 -> SRAMA sequence 14,15,0,1 with SRAMWEN=0; done 6 cycles after start.
- Mode 01, READ_LAT=3, hold high for 3 cycles mid-READ on correctly preloaded SRAM -> no access while held; all 8 compares occur; err=0; total length extended by exactly 3.
- RST asserted during the 4th write -> next cycle SRAMCEN=1, SRAMWEN=1, SRAMMUX=0, PAUSE=0, busy=0; a following start runs normally.
- Mode 11 with start re-pulsed while busy -> second start ignored; exactly N rd_valid strobes with rd_data = memory contents; err stays 0.

Source files
------------

// File: rtl/wandr_seq.sv
// rtl/wandr_seq.sv - SRAM write/readback sequencer for the BNN test path
module wandr_seq #(
  parameter int AW       = 13,
  parameter int DW       = 1,
  parameter int NBANK    = 2,
  parameter int READ_LAT = 1,
  localparam int SW      = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          sysclk,
  input  logic          RST,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] bank,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] last_addr,
  input  logic [DW-1:0] pat,
  input  logic          hold,
  input  logic [DW-1:0] SRAMDOUT,
  output logic [AW-1:0] SRAMA,
  output logic [DW-1:0] SRAMD,
  output logic          SRAMCEN,
  output logic          SRAMWEN,
  output logic [SW-1:0] SRAMSEL,
  output logic          SRAMMUX,
  output logic          PAUSE,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WRITE, S_RGAP, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [2:0] DLAST = 3'(READ_LAT - 1);

  state_t        state, nstate;
  logic [1:0]    mode_q;
  logic [SW-1:0] bank_q, nbank;
  logic [AW-1:0] base_q, last_q;
  logic [DW-1:0] pat_q;
  logic [AW-1:0] addr, naddr;
  logic [2:0]    dcnt, ndcnt;
  logic          acc, nacc, nwr, nrd;
  logic [DW-1:0] nexp;

  // Read pipeline: stage 0 is the read access currently on the SRAM pins.
  logic          pv [READ_LAT];
  logic [AW-1:0] pa [READ_LAT];
  logic [DW-1:0] out_exp;

  assign out_exp = pat_q ^ {DW{pa[READ_LAT-1][0]}};

  // Next state, next address and the access that the coming cycle will carry.
  always_comb begin
    nstate = state;
    naddr  = addr;
    ndcnt  = dcnt;
    // A WRITE/READ cycle with CEN high was a held slot: no address advance.
    acc    = ~SRAMCEN;
    case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_SETUP;
          naddr  = base_addr;
        end
      end
      S_SETUP: nstate = mode_q[0] ? S_READ : S_WRITE;
      S_WRITE: begin
        if (acc) begin
          if (addr == last_q) begin
            nstate = (mode_q == 2'b00) ? S_DONE : S_RGAP;
            naddr  = base_q;
          end else begin
            naddr = addr + 1'b1;
          end
        end
      end
      S_RGAP: nstate = S_READ;
      S_READ: begin
        if (acc) begin
          if (addr == last_q) begin
            nstate = S_DRAIN;
            ndcnt  = 3'd0;
          end else begin
            naddr = addr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt == DLAST) nstate = S_DONE;
        else               ndcnt  = dcnt + 3'd1;
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
    nwr   = (nstate == S_WRITE) && !hold;
    nrd   = (nstate == S_READ) && !hold;
    nacc  = nwr || nrd;
    nexp  = pat_q ^ {DW{naddr[0]}};
    nbank = (nstate == S_IDLE) ? '0 : ((state == S_IDLE) ? bank : bank_q);
  end

  // State, run parameters, registered SRAM/status outputs and the compare stage.
  always_ff @(posedge sysclk) begin
    if (RST) begin
      state    <= S_IDLE;
      mode_q   <= 2'b00;
      bank_q   <= '0;
      base_q   <= '0;
      last_q   <= '0;
      pat_q    <= '0;
      addr     <= '0;
      dcnt     <= 3'd0;
      SRAMA    <= '0;
      SRAMD    <= '0;
      SRAMCEN  <= 1'b1;
      SRAMWEN  <= 1'b1;
      SRAMSEL  <= '0;
      SRAMMUX  <= 1'b0;
      PAUSE    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 16'h0000;
      err_addr <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      state   <= nstate;
      addr    <= naddr;
      dcnt    <= ndcnt;
      SRAMA   <= (nstate == S_IDLE) ? '0 : naddr;
      SRAMD   <= nwr ? nexp : '0;
      SRAMCEN <= ~nacc;
      SRAMWEN <= ~nwr;
      SRAMSEL <= nbank;
      SRAMMUX <= (nstate != S_IDLE);
      PAUSE   <= (nstate != S_IDLE);
      busy    <= (nstate != S_IDLE);
      done    <= (nstate == S_DONE);

      pv[0] <= nrd;
      pa[0] <= naddr;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end

      rd_valid <= pv[READ_LAT-1];
      if (pv[READ_LAT-1]) begin
        rd_data <= SRAMDOUT;
        if (mode_q != 2'b11 && SRAMDOUT != out_exp) begin
          err <= 1'b1;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'h0001;
          if (!err) err_addr <= pa[READ_LAT-1];
        end
      end

      if (state == S_IDLE && start) begin
        mode_q   <= mode;
        bank_q   <= bank;
        base_q   <= base_addr;
        last_q   <= last_addr;
        pat_q    <= pat;
        err      <= 1'b0;
        err_cnt  <= 16'h0000;
        err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wandr_seq.sv
// tb/tb_wandr_seq.sv - scoreboard bench for wandr_seq
module tb_wandr_seq;
  localparam int AW = 4, DW = 8, NB = 4, LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [1:0]    bank = 2'b00;
  logic [AW-1:0] base = '0, last = '0;
  logic [DW-1:0] pat = '0;
  logic [DW-1:0] sdout;
  logic [AW-1:0] sa, err_addr;
  logic [DW-1:0] sd, rd_data;
  logic          cen, wen, mux, pause, rd_valid, busy, done, err;
  logic [1:0]    sel;
  logic [15:0]   err_cnt;

  wandr_seq #(.AW(AW), .DW(DW), .NBANK(NB), .READ_LAT(LAT)) dut (
    .sysclk(clk), .RST(rst), .start(start), .mode(mode), .bank(bank),
    .base_addr(base), .last_addr(last), .pat(pat), .hold(hold),
    .SRAMDOUT(sdout), .SRAMA(sa), .SRAMD(sd), .SRAMCEN(cen), .SRAMWEN(wen),
    .SRAMSEL(sel), .SRAMMUX(mux), .PAUSE(pause), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nrd = 0, nwr = 0;
  logic [1:0] cur_bank = 2'b00;
  logic       flip_en = 1'b0;
  logic [3:0] flip_addr = 4'd0;

  logic [11:0] wr_q [$];
  logic [3:0]  ra_q [$];
  logic [7:0]  rd_q [$];

  // SRAM model: write on the edge, read data capturable LAT edges after issue.
  logic [7:0] mem [NB][16];
  logic [7:0] mp [LAT-1];
  assign sdout = mp[LAT-2];

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 16; a++) mem[b][a] = 8'h00;
  end

  // SRAM array and read latency pipeline.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cen && !wen) mem[sel][sa] <= sd;
    mp[0] <= (!cen && wen) ? (mem[sel][sa] ^ ((flip_en && sa == flip_addr) ? 8'h01 : 8'h00)) : 8'h00;
    for (int i = 1; i < LAT - 1; i++) mp[i] <= mp[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected or missing event", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT accesses SRAM or strobes rd_valid.
  always @(negedge clk) begin
    if (cen === 1'b0 && wen === 1'b0) begin
      nwr++;
      if (wr_q.size() == 0) miss("wr_extra");
      else chk("wr_addr_data", {20'h0, sa, sd}, {20'h0, wr_q.pop_front()});
      chk("wr_bank", sel, cur_bank);
    end
    if (cen === 1'b0 && wen === 1'b1) begin
      nrd++;
      if (ra_q.size() == 0) miss("rdacc_extra");
      else chk("rd_addr", sa, ra_q.pop_front());
      chk("rd_bank", sel, cur_bank);
    end
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) miss("rd_extra");
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  task automatic run(input logic [1:0] m, input logic [1:0] b, input logic [3:0] ba,
                     input logic [3:0] la, input logic [7:0] p, input logic [7:0] cp,
                     input int done_at, input int hold_at, input int repulse_at,
                     input int rst_at, input logic e_err, input logic [15:0] e_cnt,
                     input logic [3:0] e_eaddr);
    int n, c0, idx;
    bit seen;
    logic [3:0] a;
    n = int'(4'(la - ba)) + 1;
    wr_q.delete(); ra_q.delete(); rd_q.delete();
    nrd = 0; nwr = 0; cur_bank = b;
    for (int i = 0; i < n; i++) begin
      a = ba + 4'(i);
      if (m == 2'b00 || m == 2'b10) wr_q.push_back({a, p ^ {8{a[0]}}});
      if (m != 2'b00) begin
        ra_q.push_back(a);
        rd_q.push_back((cp ^ {8{a[0]}}) ^ ((flip_en && a == flip_addr) ? 8'h01 : 8'h00));
      end
    end
    @(negedge clk);
    mode = m; bank = b; base = ba; last = la; pat = p; start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      idx = cyc - c0;
      hold = (hold_at > 0 && idx >= hold_at && idx < hold_at + 3);
      if (idx == repulse_at) begin
        start = 1'b1; mode = 2'b00; base = 4'd9; last = 4'd9;
      end else begin
        start = 1'b0;
      end
      if (rst_at > 0 && idx == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cen", cen, 1); chk("rst_wen", wen, 1); chk("rst_mux", mux, 0);
        chk("rst_pause", pause, 0); chk("rst_busy", busy, 0);
        chk("rst_writes_before", nwr, 4);
        rst = 1'b0;
        wr_q.delete(); ra_q.delete(); rd_q.delete();
        return;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        chk("done_cycle", idx, done_at);
        chk("done_busy", busy, 1);
        chk("err", err, e_err);
        chk("err_cnt", err_cnt, e_cnt);
        chk("err_addr", err_addr, e_eaddr);
        chk("n_writes", nwr, (m == 2'b00 || m == 2'b10) ? n : 0);
        chk("n_reads", nrd, (m == 2'b00) ? 0 : n);
        chk("sb_empty", wr_q.size() + rd_q.size() + ra_q.size(), 0);
      end else begin
        @(negedge clk);
      end
    end
    hold = 1'b0;
    start = 1'b0;
    if (!seen) begin
      miss("done_timeout");
    end else begin
      @(negedge clk);
      chk("post_busy", busy, 0); chk("post_mux", mux, 0);
      chk("post_pause", pause, 0); chk("post_done", done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_SRAMA", sa, 0); chk("rst_SRAMD", sd, 0); chk("rst_SRAMCEN", cen, 1);
    chk("rst_SRAMWEN", wen, 1); chk("rst_SRAMSEL", sel, 0); chk("rst_SRAMMUX", mux, 0);
    chk("rst_PAUSE", pause, 0); chk("rst_rd_data", rd_data, 0); chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0); chk("rst_err_addr", err_addr, 0);
    rst = 1'b0;

    // write-then-verify, clean: 2N+LAT+3 = 21
    run(2'b10, 2'd1, 4'd0, 4'd7, 8'hA5, 8'hA5, 21, 0, -1, 0, 1'b0, 16'd0, 4'd0);
    // same with bit 0 flipped on readback of address 3
    flip_en = 1'b1; flip_addr = 4'd3;
    run(2'b10, 2'd1, 4'd0, 4'd7, 8'hA5, 8'hA5, 21, 0, -1, 0, 1'b1, 16'd1, 4'd3);
    flip_en = 1'b0;
    // write-only wrapping 14,15,0,1: N+2 = 6
    run(2'b00, 2'd2, 4'd14, 4'd1, 8'h3C, 8'h3C, 6, 0, -1, 0, 1'b0, 16'd0, 4'd0);
    // verify-only with 3 held cycles: N+LAT+2+3 = 15
    run(2'b01, 2'd1, 4'd0, 4'd7, 8'hA5, 8'hA5, 15, 4, -1, 0, 1'b0, 16'd0, 4'd0);
    // reset during the 4th write (cycle 5), then a normal short run: N+2 = 4
    run(2'b00, 2'd0, 4'd0, 4'd7, 8'h11, 8'h11, 0, 0, -1, 5, 1'b0, 16'd0, 4'd0);
    run(2'b00, 2'd3, 4'd5, 4'd6, 8'h77, 8'h77, 4, 0, -1, 0, 1'b0, 16'd0, 4'd0);
    // read-dump of bank 2 with start re-pulsed while busy: N+LAT+2 = 8
    run(2'b11, 2'd2, 4'd14, 4'd1, 8'h00, 8'h3C, 8, 0, 3, 0, 1'b0, 16'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
